// File: rtl/imem_fetch_arbiter_pkg.sv
// Shared parameters, FSM state type and small index helpers for the instruction-fetch arbiter.
package imem_fetch_arbiter_pkg;

    localparam int NUM_SIMD_CORES  = 4;
    localparam int LOG2_SIMD_CORES = 2;
    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } fetch_state_t;

    // Next core index in round-robin order, wrapping past the last core.
    function automatic logic [LOG2_SIMD_CORES-1:0] next_core(input logic [LOG2_SIMD_CORES-1:0] idx);
        if (idx == LOG2_SIMD_CORES'(NUM_SIMD_CORES - 1)) begin
            next_core = {LOG2_SIMD_CORES{1'b0}};
        end else begin
            next_core = idx + {{(LOG2_SIMD_CORES-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic logic [NUM_SIMD_CORES-1:0] core_onehot(input logic [LOG2_SIMD_CORES-1:0] idx);
        core_onehot = {{(NUM_SIMD_CORES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/imem_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin winner select: the first requester at or after the pointer wins.
module rr_arbiter
    import imem_fetch_arbiter_pkg::*;
(
    input  logic [NUM_SIMD_CORES-1:0]  req_i,
    input  logic [LOG2_SIMD_CORES-1:0] ptr_i,
    output logic [LOG2_SIMD_CORES-1:0] winner_o,
    output logic                       any_req_o
);

    logic [LOG2_SIMD_CORES-1:0] idx_s;
    logic                       found_s;

    // Walk the cores starting at the pointer and latch the first one requesting.
    always_comb begin
        winner_o  = ptr_i;
        any_req_o = |req_i;
        found_s   = 1'b0;
        idx_s     = ptr_i;
        for (int k = 0; k < NUM_SIMD_CORES; k++) begin
            if (!found_s && req_i[idx_s]) begin
                winner_o = idx_s;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
            idx_s = next_core(idx_s);
        end
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares the single instruction-memory read port between the SIMD cores, one transaction at a time.
module imem_fetch_arbiter
    import imem_fetch_arbiter_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SIMD_CORES-1:0]            fetch_req,
    input  logic [NUM_SIMD_CORES*ADDR_WIDTH-1:0] fetch_pc,
    output logic [NUM_SIMD_CORES-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]                instruction_out,
    output logic                                 mem_req,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    input  logic                                 mem_ready,
    input  logic                                 mem_rvalid,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    output logic [LOG2_SIMD_CORES-1:0]           grant_id,
    output logic                                 busy
);

    fetch_state_t               state_q;
    logic [LOG2_SIMD_CORES-1:0] ptr_q;
    logic [LOG2_SIMD_CORES-1:0] grant_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]      inst_q;
    logic [NUM_SIMD_CORES-1:0]  resp_q;
    logic                       req_q;
    logic                       busy_q;

    logic [LOG2_SIMD_CORES-1:0] winner_s;
    logic                       any_req_s;
    logic [ADDR_WIDTH-1:0]      pc_sel_s;

    rr_arbiter u_rr_arbiter (
        .req_i     (fetch_req),
        .ptr_i     (ptr_q),
        .winner_o  (winner_s),
        .any_req_o (any_req_s)
    );

    // Address of the core the arbiter would grant this cycle.
    always_comb begin
        pc_sel_s = fetch_pc[winner_s*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Fetch FSM; every output is a register so the cores and imem see glitch-free signals.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= {LOG2_SIMD_CORES{1'b0}};
            grant_q <= {LOG2_SIMD_CORES{1'b0}};
            addr_q  <= {ADDR_WIDTH{1'b0}};
            inst_q  <= {DATA_WIDTH{1'b0}};
            resp_q  <= {NUM_SIMD_CORES{1'b0}};
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req_s) begin
                        grant_q <= winner_s;
                        addr_q  <= pc_sel_s;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        inst_q  <= mem_rdata;
                        resp_q  <= core_onehot(grant_q);
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // Pointer moves past the served core so it loses priority next round.
                    resp_q  <= {NUM_SIMD_CORES{1'b0}};
                    ptr_q   <= next_core(grant_q);
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    resp_q  <= {NUM_SIMD_CORES{1'b0}};
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid      = resp_q;
    assign instruction_out = inst_q;
    assign mem_req         = req_q;
    assign mem_addr        = addr_q;
    assign grant_id        = grant_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter: a transaction-level model checked every cycle plus literal expectations.
module tb_imem_fetch_arbiter;
    import imem_fetch_arbiter_pkg::*;

    localparam int N  = NUM_SIMD_CORES;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int LW = LOG2_SIMD_CORES;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    fetch_req;
    logic [N*AW-1:0] fetch_pc;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   instruction_out;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic [LW-1:0]   grant_id;
    logic            busy;

    imem_fetch_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_req       (fetch_req),
        .fetch_pc        (fetch_pc),
        .resp_valid      (resp_valid),
        .instruction_out (instruction_out),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .grant_id        (grant_id),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- imem responder ----------------
    int          stall_left = 0;
    int          rv_delay   = 0;
    int          pend       = 0;
    logic        stray_rv   = 1'b0;
    logic        stray_rdy  = 1'b0;
    logic [31:0] pend_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0040) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    initial begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        pend_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            if (!rst) begin
                pend       = 0;
                stall_left = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = pend_data;
                    end
                end else if (mem_req) begin
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        mem_ready = 1'b1;
                        pend      = 1 + rv_delay;
                        pend_data = mem_word(mem_addr);
                    end
                end
                if (stray_rv && !mem_rvalid) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'h0BAD_0BAD;
                end
                if (stray_rdy) mem_ready = 1'b1;
            end
        end
    end

    // ---------------- transaction model + per-cycle compare ----------------
    int          g_core[$];
    logic [31:0] g_addr[$];
    int          r_cyc[$];
    logic [3:0]  r_vec[$];
    logic [31:0] r_inst[$];
    int          mreq_cnt = 0;

    initial begin
        bit          m_active, m_acc, m_got, prev_busy;
        int          m_ptr, m_grant;
        logic [31:0] m_addr, m_inst;
        logic [3:0]  ev;
        m_active = 0; m_acc = 0; m_got = 0; prev_busy = 0;
        m_ptr = 0; m_grant = 0; m_addr = 0; m_inst = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_active = 0; m_acc = 0; m_got = 0; prev_busy = 0;
                m_ptr = 0; m_grant = 0; m_addr = 0; m_inst = 0;
                check("rst_mem_req", mem_req, 0);
                check("rst_busy", busy, 0);
                check("rst_resp_valid", resp_valid, 0);
            end else begin
                ev = 4'b0000;
                if (m_active && m_got) ev[m_grant] = 1'b1;
                check("mem_req", mem_req, m_active && !m_acc);
                check("busy", busy, m_active);
                check("resp_valid", resp_valid, ev);
                check("grant_id", grant_id, m_grant);
                check("mem_addr", mem_addr, m_addr);
                check("instruction_out", instruction_out, m_inst);
                check("resp_onehot", ($countones(resp_valid) <= 1), 1);

                if (busy && !prev_busy) begin
                    g_core.push_back(int'(grant_id));
                    g_addr.push_back(mem_addr);
                end
                if (|resp_valid) begin
                    r_cyc.push_back(cyc);
                    r_vec.push_back(resp_valid);
                    r_inst.push_back(instruction_out);
                end
                if (mem_req) mreq_cnt++;
                prev_busy = busy;

                // Advance the transaction by what the inputs did this cycle.
                if (!m_active) begin
                    if (|fetch_req) begin
                        for (int k = N - 1; k >= 0; k--) begin
                            if (fetch_req[(m_ptr + k) % N]) m_grant = (m_ptr + k) % N;
                        end
                        m_active = 1; m_acc = 0; m_got = 0;
                        m_addr   = fetch_pc[m_grant*AW +: AW];
                    end
                end else if (!m_acc) begin
                    if (mem_ready) m_acc = 1;
                end else if (!m_got) begin
                    if (mem_rvalid) begin
                        m_got  = 1;
                        m_inst = mem_rdata;
                    end
                end else begin
                    m_active = 0;
                    m_ptr    = (m_grant + 1) % N;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_resps(input int n);
        int t = 0;
        while (r_vec.size() < n && t < 200) begin
            samp();
            t++;
        end
        check("resp_count", r_vec.size(), n);
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (g_core.size() < n && t < 200) begin
            samp();
            t++;
        end
        check("grant_count", g_core.size(), n);
    endtask

    task automatic wait_idle();
        int t = 0;
        samp();
        while (busy && t < 200) begin
            samp();
            t++;
        end
        check("idle", busy, 0);
    endtask

    task automatic set_pc(input int i, input logic [31:0] v);
        fetch_pc[i*AW +: AW] = v;
    endtask

    initial begin
        int c0, gb, rb, mc0, nresp, t;
        int fo[5];
        rst       = 1'b0;
        fetch_req = '0;
        fetch_pc  = '0;

        // Reset state
        repeat (2) samp();
        check("reset_busy", busy, 0);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_mem_req", mem_req, 0);
        check("reset_grant_id", grant_id, 0);
        check("reset_instruction", instruction_out, 0);
        tick(); rst = 1'b1;

        // Single fetch from core 1
        tick(); set_pc(1, 32'h0000_0040); fetch_req = 4'b0010; c0 = cyc;
        tick(); fetch_req = 4'b0000;
        wait_resps(1);
        check("single_vec", r_vec[0], 4'b0010);
        check("single_data", r_inst[0], 32'hDEAD_BEEF);
        check("single_latency", r_cyc[0] - c0, 3);
        check("single_grant", g_core[0], 1);
        check("single_addr", g_addr[0], 32'h0000_0040);
        wait_idle();

        // Reset in the middle of ISSUE with core 2 granted
        tick(); stall_left = 10; set_pc(2, 32'h0000_0200); fetch_req = 4'b0100;
        wait_grants(2);
        check("rst_mid_grant", g_core[1], 2);
        check("rst_mid_in_issue", mem_req, 1);
        tick(); rst = 1'b0; fetch_req = 4'b0000;
        samp();
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_resp", resp_valid, 0);
        nresp = r_vec.size();
        tick(); rst = 1'b1; stray_rv = 1'b1; stray_rdy = 1'b1;
        repeat (3) tick();
        stray_rv = 1'b0; stray_rdy = 1'b0;
        samp();
        check("stale_no_resp", r_vec.size(), nresp);
        check("stale_idle", busy, 0);
        check("stale_instruction", instruction_out, 0);

        // Fairness: everyone requests, pointer restarted at 0
        tick();
        for (int i = 0; i < N; i++) set_pc(i, 32'h0000_1000 + 32'(i * 16));
        fetch_req = 4'b1111; gb = g_core.size(); rb = r_vec.size();
        wait_resps(rb + 5);
        tick(); fetch_req = 4'b0000;
        fo = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            check("fair_grant", g_core[gb + k], fo[k]);
            check("fair_addr", g_addr[gb + k], 32'h0000_1000 + 32'(fo[k] * 16));
        end
        wait_idle();

        // Backpressure: mem_ready low for 5 cycles
        tick(); stall_left = 5; mc0 = mreq_cnt; rb = r_vec.size();
        fetch_req = 4'b0100; c0 = cyc;
        tick(); fetch_req = 4'b0000;
        wait_resps(rb + 1);
        check("bp_latency", r_cyc[rb] - c0, 8);
        check("bp_vec", r_vec[rb], 4'b0100);
        check("bp_data", r_inst[rb], 32'h5A5A_1020);
        check("bp_req_cycles", mreq_cnt - mc0, 6);
        wait_idle();

        // Withdrawn request: core 3 drops fetch_req while waiting for data
        tick(); rv_delay = 3; set_pc(3, 32'h0000_0300); fetch_req = 4'b1000;
        gb = g_core.size(); rb = r_vec.size();
        wait_grants(gb + 1);
        t = 0;
        while (!(busy && !mem_req) && t < 50) begin
            samp();
            t++;
        end
        tick(); fetch_req = 4'b0000;
        samp();
        check("wd_dropped_in_wait", busy && !mem_req && !(|resp_valid), 1);
        wait_resps(rb + 1);
        check("wd_vec", r_vec[rb], 4'b1000);
        check("wd_data", r_inst[rb], 32'h5A5A_0300);
        rv_delay = 0;
        repeat (6) samp();
        check("wd_no_regrant", g_core.size(), gb + 1);
        check("wd_single_pulse", r_vec.size(), rb + 1);

        // Wrap-around: serve core 2 so the pointer sits at 3, then cores 0 and 2 request
        tick(); fetch_req = 4'b0100; rb = r_vec.size();
        tick(); fetch_req = 4'b0000;
        wait_resps(rb + 1);
        wait_idle();
        tick(); fetch_req = 4'b0101; gb = g_core.size(); rb = r_vec.size();
        wait_resps(rb + 2);
        tick(); fetch_req = 4'b0000;
        check("wrap_first", g_core[gb], 0);
        check("wrap_second", g_core[gb + 1], 2);
        check("wrap_first_vec", r_vec[rb], 4'b0001);
        check("wrap_second_vec", r_vec[rb + 1], 4'b0100);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
